// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects, register numbers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef logic [2:0] reg_num_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; load enables and flushes are the datapath's stall mechanism.
interface pipeline_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int STACK_DEPTH = 8
) ();
   localparam int DW = $clog2(STACK_DEPTH + 1);

   // datapath stage information
   reg_num_t        ID_RegRs;
   reg_num_t        ID_RegRt;
   reg_num_t        EX_RegRs;
   reg_num_t        EX_RegRt;
   reg_num_t        EX_RegRd;
   logic            EX_MemRead;
   logic            EX_change_C_Z;
   logic            zero_out;
   logic            carry_out;
   reg_num_t        MEM_RegRd;
   logic            MEM_RegWrite;
   reg_num_t        WB_RegRd;
   logic            WB_RegWrite;
   logic            id_branch_taken;
   logic            id_push;
   logic            id_pop;
   logic            halt_req;

   // controls back to the datapath
   logic            ldPC;
   logic            ld_IF_ID;
   logic            IF_Flush;
   logic            ID_EX_flush;
   logic [1:0]      ForwardA;
   logic [1:0]      ForwardB;
   logic            sel_carry_forwarding;
   logic            carry_forwarding;
   logic            sel_zero_forwarding;
   logic            zero_forwarding;
   logic            push;
   logic            pop;
   logic [DW-1:0]   stack_depth;
   logic            stack_err;
   logic            halted;
   logic [15:0]     stall_cnt;
   logic [15:0]     flush_cnt;

   modport master (
      output ID_RegRs, ID_RegRt, EX_RegRs, EX_RegRt, EX_RegRd, EX_MemRead,
             EX_change_C_Z, zero_out, carry_out, MEM_RegRd, MEM_RegWrite,
             WB_RegRd, WB_RegWrite, id_branch_taken, id_push, id_pop, halt_req,
      input  ldPC, ld_IF_ID, IF_Flush, ID_EX_flush, ForwardA, ForwardB,
             sel_carry_forwarding, carry_forwarding, sel_zero_forwarding,
             zero_forwarding, push, pop, stack_depth, stack_err, halted,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  ID_RegRs, ID_RegRt, EX_RegRs, EX_RegRt, EX_RegRd, EX_MemRead,
             EX_change_C_Z, zero_out, carry_out, MEM_RegRd, MEM_RegWrite,
             WB_RegRd, WB_RegWrite, id_branch_taken, id_push, id_pop, halt_req,
      output ldPC, ld_IF_ID, IF_Flush, ID_EX_flush, ForwardA, ForwardB,
             sel_carry_forwarding, carry_forwarding, sel_zero_forwarding,
             zero_forwarding, push, pop, stack_depth, stack_err, halted,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/fwd_select.sv
// Operand forward select for one EX source register; the younger MEM result beats WB.
// Latency: combinational.
// Backpressure: none.
module fwd_select
   import pipe_ctrl_pkg::*;
(
   input  reg_num_t   ex_reg,
   input  reg_num_t   mem_rd,
   input  logic       mem_wr,
   input  reg_num_t   wb_rd,
   input  logic       wb_wr,
   output logic [1:0] fwd
);

   // priority compare; register 0 is an ordinary register and forwards too
   always_comb begin
      fwd = FWD_REG;
      if (mem_wr && (mem_rd == ex_reg))
         fwd = FWD_MEM;
      else if (wb_wr && (wb_rd == ex_reg))
         fwd = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush, halt/drain FSM, call-stack depth.
// Latency: controls combinational from stage inputs; halted/stack state registered (1 cycle).
// Backpressure: stalls the front end via ldPC/ld_IF_ID; HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STACK_DEPTH  = 8,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic          halted_q;
   logic [DW-1:0] depth;
   logic          err;
   logic          if_flush_q;   // IF/ID was flushed last edge: ID holds a bubble
   logic          load_use;
   logic          ld_pc, ld_if_id, if_flush, id_ex_flush;
   logic          push, pop;
   logic [1:0]    fwd_a, fwd_b;

   fwd_select u_fwd_a (
      .ex_reg (bus.EX_RegRs),
      .mem_rd (bus.MEM_RegRd),
      .mem_wr (bus.MEM_RegWrite),
      .wb_rd  (bus.WB_RegRd),
      .wb_wr  (bus.WB_RegWrite),
      .fwd    (fwd_a)
   );

   fwd_select u_fwd_b (
      .ex_reg (bus.EX_RegRt),
      .mem_rd (bus.MEM_RegRd),
      .mem_wr (bus.MEM_RegWrite),
      .wb_rd  (bus.WB_RegRd),
      .wb_wr  (bus.WB_RegWrite),
      .fwd    (fwd_b)
   );

   assign load_use = bus.EX_MemRead &&
                     ((bus.EX_RegRd == bus.ID_RegRs) || (bus.EX_RegRd == bus.ID_RegRt));

   // front-end controls: reset > freeze (DRAIN/HALTED) > load-use bubble > taken branch
   always_comb begin
      ld_pc       = 1'b1;
      ld_if_id    = 1'b1;
      if_flush    = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         if_flush    = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state != RUN || load_use) begin
         ld_pc       = 1'b0;
         ld_if_id    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (bus.id_branch_taken) begin
         if_flush    = 1'b1;
      end
   end

   // a held, stalled or flushed ID instruction must not touch the stack
   assign push = ~reset & bus.id_push & ld_if_id & ~if_flush_q;
   assign pop  = ~reset & bus.id_pop  & ld_if_id & ~if_flush_q;

   // halt/drain sequencing; halted is registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted_q  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (bus.halt_req) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (!bus.halt_req) begin
                  state <= RUN;
               end else if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
                  state    <= HALTED;
                  halted_q <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + CW'(1);
               end
            end
            HALTED: begin
               if (!bus.halt_req) begin
                  state    <= RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state    <= RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   // call-stack depth tracking with saturation and a sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         depth      <= '0;
         err        <= 1'b0;
         if_flush_q <= 1'b1;
      end else begin
         if_flush_q <= if_flush;
         if (push && !pop) begin
            if (depth == DW'(STACK_DEPTH)) err   <= 1'b1;
            else                           depth <= depth + DW'(1);
         end else if (pop && !push) begin
            if (depth == '0) err   <= 1'b1;
            else             depth <= depth - DW'(1);
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_q, flush_q;

   // saturating stall and flush event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (((state == RUN && load_use) || state == DRAIN) && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (if_flush && flush_q != 16'hFFFF)
            flush_q <= flush_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_q;
   assign bus.flush_cnt = flush_q;
`else
   assign bus.stall_cnt = 16'd0;
   assign bus.flush_cnt = 16'd0;
`endif

   assign bus.ldPC                 = ld_pc;
   assign bus.ld_IF_ID             = ld_if_id;
   assign bus.IF_Flush             = if_flush;
   assign bus.ID_EX_flush          = id_ex_flush;
   assign bus.ForwardA             = reset ? FWD_REG : fwd_a;
   assign bus.ForwardB             = reset ? FWD_REG : fwd_b;
   assign bus.sel_carry_forwarding = bus.EX_change_C_Z;
   assign bus.carry_forwarding     = bus.EX_change_C_Z & bus.carry_out;
   assign bus.sel_zero_forwarding  = bus.EX_change_C_Z;
   assign bus.zero_forwarding      = bus.EX_change_C_Z & bus.zero_out;
   assign bus.push                 = push;
   assign bus.pop                  = pop;
   assign bus.stack_depth          = depth;
   assign bus.stack_err            = err;
   assign bus.halted               = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: expectations queued at drive time, popped at sample time.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.STACK_DEPTH(8)) bus ();

   pipeline_hazard_ctrl #(.STACK_DEPTH(8), .DRAIN_CYCLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [19:0] val;
      logic [19:0] msk;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // {ctl[3:0], fwdA, fwdB, flags[3:0], push, pop, halted, err, depth[3:0]}
   logic [19:0] obs;
   assign obs = {bus.ldPC, bus.ld_IF_ID, bus.IF_Flush, bus.ID_EX_flush,
                 bus.ForwardA, bus.ForwardB,
                 bus.sel_carry_forwarding, bus.carry_forwarding,
                 bus.sel_zero_forwarding, bus.zero_forwarding,
                 bus.push, bus.pop, bus.halted, bus.stack_err, bus.stack_depth};

   localparam logic [19:0] M_CTL = 20'hF0000;
   localparam logic [19:0] M_FWD = 20'h0F000;
   localparam logic [19:0] M_FLG = 20'h00F00;
   localparam logic [19:0] M_PP  = 20'h000C0;
   localparam logic [19:0] M_HLT = 20'h00020;
   localparam logic [19:0] M_ERR = 20'h00010;
   localparam logic [19:0] M_DEP = 20'h0000F;

   // {ldPC, ld_IF_ID, IF_Flush, ID_EX_flush}
   localparam logic [3:0] C_RUN = 4'b1100;
   localparam logic [3:0] C_STL = 4'b0001;
   localparam logic [3:0] C_BR  = 4'b1110;
   localparam logic [3:0] C_FRZ = 4'b0001;
   localparam logic [3:0] C_RST = 4'b1111;

   function automatic logic [19:0] mk(logic [3:0] c, logic [3:0] f, logic [3:0] g,
                                      logic [1:0] p, logic h, logic e, logic [3:0] d);
      return {c, f, g, p, h, e, d};
   endfunction

   task automatic idle();
      bus.ID_RegRs = 3'd0;  bus.ID_RegRt = 3'd0;
      bus.EX_RegRs = 3'd0;  bus.EX_RegRt = 3'd0;  bus.EX_RegRd = 3'd0;
      bus.EX_MemRead = 1'b0; bus.EX_change_C_Z = 1'b0;
      bus.zero_out = 1'b0;  bus.carry_out = 1'b0;
      bus.MEM_RegRd = 3'd0; bus.MEM_RegWrite = 1'b0;
      bus.WB_RegRd = 3'd0;  bus.WB_RegWrite = 1'b0;
      bus.id_branch_taken = 1'b0; bus.id_push = 1'b0; bus.id_pop = 1'b0;
      bus.halt_req = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      idle();
      reset = 1'b1;
      bus.EX_MemRead = 1'b1; bus.EX_RegRd = 3'd2; bus.ID_RegRt = 3'd2;
      bus.MEM_RegWrite = 1'b1; bus.id_push = 1'b1; bus.id_branch_taken = 1'b1;
      @(negedge clk);
      sb.push_back('{"reset_outputs", mk(C_RST, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd0),
                     M_CTL | M_FWD | M_PP | M_HLT | M_ERR | M_DEP});
      #1;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.msk) !== (e.val & e.msk)) begin
         n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
      end
      n_chk++;
      if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", bus.stall_cnt, bus.flush_cnt);
      end
      reset = 1'b0;
      idle();
      @(negedge clk);
      sb.push_back('{"first_run_cycle", mk(C_RUN, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd0),
                     M_CTL | M_HLT | M_ERR | M_DEP});
      #1;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.msk) !== (e.val & e.msk)) begin
         n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
      end
   endtask

   task automatic test_forward();
      exp_t e;
      // {memw, memrd, wbw, wbrd, rs, rt, fwdA, fwdB}
      logic [17:0] tbl [6];
      tbl[0] = {1'b1, 3'd3, 1'b1, 3'd3, 3'd3, 3'd5, 2'b10, 2'b00};
      tbl[1] = {1'b0, 3'd3, 1'b1, 3'd3, 3'd3, 3'd5, 2'b01, 2'b00};
      tbl[2] = {1'b1, 3'd5, 1'b1, 3'd3, 3'd3, 3'd5, 2'b01, 2'b10};
      tbl[3] = {1'b1, 3'd0, 1'b1, 3'd0, 3'd0, 3'd0, 2'b10, 2'b10};
      tbl[4] = {1'b0, 3'd2, 1'b0, 3'd2, 3'd2, 3'd2, 2'b00, 2'b00};
      tbl[5] = {1'b1, 3'd7, 1'b1, 3'd6, 3'd6, 3'd7, 2'b01, 2'b10};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle();
         bus.MEM_RegWrite = tbl[i][17]; bus.MEM_RegRd = tbl[i][16:14];
         bus.WB_RegWrite  = tbl[i][13]; bus.WB_RegRd  = tbl[i][12:10];
         bus.EX_RegRs     = tbl[i][9:7]; bus.EX_RegRt = tbl[i][6:4];
         sb.push_back('{$sformatf("forward_%0d", i),
                        mk(C_RUN, tbl[i][3:0], 4'h0, 2'b00, 1'b0, 1'b0, 4'd0), M_CTL | M_FWD});
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
      idle();
   endtask

   task automatic test_flags();
      exp_t e;
      // {change_C_Z, carry_out, zero_out, {sel_c, c_fwd, sel_z, z_fwd}}
      logic [6:0] tbl [3];
      tbl[0] = {1'b1, 1'b1, 1'b0, 4'b1110};
      tbl[1] = {1'b1, 1'b0, 1'b1, 4'b1011};
      tbl[2] = {1'b0, 1'b1, 1'b1, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         bus.EX_change_C_Z = tbl[i][6]; bus.carry_out = tbl[i][5]; bus.zero_out = tbl[i][4];
         sb.push_back('{$sformatf("flags_%0d", i),
                        mk(4'h0, 4'h0, tbl[i][3:0], 2'b00, 1'b0, 1'b0, 4'd0),
                        tbl[i][6] ? M_FLG : 20'h00A00});
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
      idle();
   endtask

   task automatic test_load_use();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         idle();
         case (i)
            0: begin
               bus.EX_MemRead = 1'b1; bus.EX_RegRd = 3'd2; bus.ID_RegRt = 3'd2;
               bus.ID_RegRs = 3'd4; bus.id_push = 1'b1;
               sb.push_back('{"lu_rt_stall", mk(C_STL, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd0), M_CTL | M_PP});
            end
            1: begin
               bus.EX_RegRd = 3'd2; bus.ID_RegRt = 3'd2; bus.ID_RegRs = 3'd4; bus.id_push = 1'b1;
               sb.push_back('{"lu_bubble_resume", mk(C_RUN, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 4'd0), M_CTL | M_PP});
            end
            2: begin
               bus.EX_MemRead = 1'b1; bus.EX_RegRd = 3'd4; bus.ID_RegRs = 3'd4; bus.ID_RegRt = 3'd1;
               sb.push_back('{"lu_rs_stall", mk(C_STL, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd1), M_CTL | M_PP | M_DEP});
            end
            3: begin
               bus.EX_MemRead = 1'b1; bus.EX_RegRd = 3'd6; bus.ID_RegRs = 3'd4; bus.ID_RegRt = 3'd1;
               sb.push_back('{"lu_no_match", mk(C_RUN, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd1), M_CTL | M_DEP});
            end
            default: begin
               bus.id_branch_taken = 1'b1;
               sb.push_back('{"branch_plain", mk(C_BR, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd1), M_CTL});
            end
         endcase
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
      idle();
   endtask

   task automatic test_branch_stall();
      exp_t e;
      logic [3:0] exp_ctl [3];
      exp_ctl[0] = C_STL; exp_ctl[1] = C_BR; exp_ctl[2] = C_RUN;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         bus.id_branch_taken = (i < 2);
         bus.EX_MemRead = (i == 0);
         bus.EX_RegRd = 3'd3; bus.ID_RegRs = 3'd3;
         sb.push_back('{$sformatf("branch_vs_stall_%0d", i),
                        mk(exp_ctl[i], 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd0), M_CTL});
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
      idle();
   endtask

   task automatic test_halt();
      exp_t e;
      // {halt_req, branch, load_use, reset, ctl[3:0], halted}
      logic [8:0] seq [22];
      seq[0]  = {1'b1, 1'b1, 1'b0, 1'b0, C_BR,  1'b0};
      seq[1]  = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[2]  = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[3]  = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[4]  = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1};
      seq[5]  = {1'b0, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1};
      seq[6]  = {1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0};
      seq[7]  = {1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0};
      seq[8]  = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[9]  = {1'b0, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[10] = {1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0};
      seq[11] = {1'b1, 1'b0, 1'b1, 1'b0, C_STL, 1'b0};
      seq[12] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[13] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[14] = {1'b1, 1'b0, 1'b0, 1'b1, C_RST, 1'b0};
      seq[15] = {1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0};
      seq[16] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[17] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[18] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b0};
      seq[19] = {1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1};
      seq[20] = {1'b0, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1};
      seq[21] = {1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0};
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         idle();
         bus.halt_req = seq[i][8];
         bus.id_branch_taken = seq[i][7];
         bus.EX_MemRead = seq[i][6]; bus.EX_RegRd = 3'd5; bus.ID_RegRs = 3'd5;
         reset = seq[i][5];
         sb.push_back('{$sformatf("halt_seq_%0d", i),
                        mk(seq[i][4:1], 4'h0, 4'h0, 2'b00, seq[i][0], 1'b0, 4'd0), M_CTL | M_HLT});
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
         if (i == 15) begin
            n_chk++;
            if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
               n_fail++; $display("FAIL counters_after_reset: got %h/%h expected 0/0", bus.stall_cnt, bus.flush_cnt);
            end
         end
      end
      reset = 1'b0;
      idle();
   endtask

   task automatic test_stack_underflow();
      exp_t e;
      reset = 1'b1; idle();
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      bus.id_pop = 1'b1;
      sb.push_back('{"pop_at_empty", mk(4'h0, 4'h0, 4'h0, 2'b01, 1'b0, 1'b0, 4'd0), M_PP | M_ERR | M_DEP});
      #1;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.msk) !== (e.val & e.msk)) begin
         n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle();
         sb.push_back('{$sformatf("underflow_err_%0d", i),
                        mk(4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 4'd0), M_PP | M_ERR | M_DEP});
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
   endtask

   task automatic test_stack_overflow();
      exp_t e;
      int md = 0;
      logic me = 1'b0;
      logic [1:0] ops [13];
      for (int i = 0; i < 9; i++) ops[i] = 2'b10;
      ops[9] = 2'b11; ops[10] = 2'b01; ops[11] = 2'b00; ops[12] = 2'b00;
      reset = 1'b1; idle();
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge clk);
         bus.id_push = ops[i][1]; bus.id_pop = ops[i][0];
         sb.push_back('{$sformatf("stack_op_%0d", i),
                        mk(4'h0, 4'h0, 4'h0, ops[i], 1'b0, me, 4'(md)), M_PP | M_ERR | M_DEP});
         if (ops[i] == 2'b10) begin
            if (md == 8) me = 1'b1; else md++;
         end else if (ops[i] == 2'b01) begin
            if (md == 0) me = 1'b1; else md--;
         end
         #1;
         e = sb.pop_front(); n_chk++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.msk, e.val & e.msk);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_forward();
      test_flags();
      test_load_use();
      test_branch_stall();
      test_halt();
      test_stack_underflow();
      test_stack_overflow();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
